// File: rtl/biu_constants_pkg.sv
// Shared BIU definitions: access-size type and size encodings.
package biu_constants_pkg;

  typedef logic [2:0] biu_size_t;

  localparam biu_size_t BYTE  = 3'b000;
  localparam biu_size_t HWORD = 3'b001;
  localparam biu_size_t WORD  = 3'b010;
  localparam biu_size_t DWORD = 3'b011;
  localparam biu_size_t QWORD = 3'b100;

endpackage

// File: rtl/riscv_dmem_arb_pkg.sv
// Types shared by the data-memory arbiter and its helpers.
package riscv_dmem_arb_pkg;

  // Bus ownership state of the arbiter.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_t;

  // Master identifiers, also used to encode the last owner for round-robin.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/riscv_dmem_arb_pending.sv
// Outstanding-transaction counter for the data-memory arbiter.
// Counts up on issue, down on acknowledge, saturates at zero.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   inc            a request is issued this cycle
//   dec            an acknowledge arrives this cycle
//   pending        current number of outstanding requests
//   full           pending == MAX_PENDING
//   next_zero      count will be zero after this cycle
module riscv_dmem_arb_pending #(
  parameter int unsigned MAX_PENDING = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               inc,
  input  logic                               dec,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
  output logic                               full,
  output logic                               next_zero
);

  localparam int unsigned CW = $clog2(MAX_PENDING + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc && (cnt_q != '0)) begin
      // A stray ack with nothing outstanding must not wrap the counter.
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pending   = cnt_q;
  assign full      = (cnt_q == CW'(MAX_PENDING));
  assign next_zero = (cnt_d == '0);

endmodule

// File: rtl/riscv_dmem_arbiter.sv
// Data-memory arbiter: shares the single data BIU port between the LSU (master 0)
// and an auxiliary master (master 1). Round-robin ownership, bus-lock support,
// bounded outstanding requests and ack/data/error routing back to the owner.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   mN_req/lock/we/size/adr/d_i    master N request fields
//   mN_gnt_o                       master N request accepted this cycle
//   mN_ack/q/err_o                 master N completion, read data, error
//   mem_req/lock/we/size/adr/d_o   forwarded request to the BIU
//   mem_ack/q/misaligned/page_fault_i  BIU completion
module riscv_dmem_arbiter
  import biu_constants_pkg::*;
  import riscv_dmem_arb_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MAX_PENDING = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,

  input  logic            m0_req_i,
  input  logic            m0_lock_i,
  input  logic            m0_we_i,
  input  biu_size_t       m0_size_i,
  input  logic [XLEN-1:0] m0_adr_i,
  input  logic [XLEN-1:0] m0_d_i,
  output logic            m0_gnt_o,
  output logic            m0_ack_o,
  output logic [XLEN-1:0] m0_q_o,
  output logic            m0_err_o,

  input  logic            m1_req_i,
  input  logic            m1_lock_i,
  input  logic            m1_we_i,
  input  biu_size_t       m1_size_i,
  input  logic [XLEN-1:0] m1_adr_i,
  input  logic [XLEN-1:0] m1_d_i,
  output logic            m1_gnt_o,
  output logic            m1_ack_o,
  output logic [XLEN-1:0] m1_q_o,
  output logic            m1_err_o,

  output logic            mem_req_o,
  output logic            mem_lock_o,
  output logic            mem_we_o,
  output biu_size_t       mem_size_o,
  output logic [XLEN-1:0] mem_adr_o,
  output logic [XLEN-1:0] mem_d_o,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] mem_q_i,
  input  logic            mem_misaligned_i,
  input  logic            mem_page_fault_i
);

  localparam int unsigned CW = $clog2(MAX_PENDING + 1);

  owner_t        owner_q, owner_d;
  logic          last_q, last_d;
  logic          sel;
  logic          sel_req, sel_lock, oth_req;
  logic          preempt, issue, ack_vld, err;
  logic [CW-1:0] pending;
  logic          full, next_zero;

  // Selected master: the owner, or the round-robin winner while unowned.
  always_comb begin
    sel = M0;
    case (owner_q)
      OWN0:    sel = M0;
      OWN1:    sel = M1;
      default: begin
        if (m0_req_i && m1_req_i) begin
          sel = ~last_q;
        end else if (m1_req_i) begin
          sel = M1;
        end else begin
          sel = M0;
        end
      end
    endcase
  end

  assign sel_req  = (sel == M1) ? m1_req_i  : m0_req_i;
  assign sel_lock = (sel == M1) ? m1_lock_i : m0_lock_i;
  assign oth_req  = (sel == M1) ? m0_req_i  : m1_req_i;

  // An unlocked owner stops issuing when the other master waits, so it drains and releases.
  assign preempt = (owner_q != NONE) && oth_req && !sel_lock;

  // A same-cycle ack frees a slot, so a full counter may still accept.
  assign issue = rst_ni && sel_req && !preempt && (!full || mem_ack_i);

  // Acks with nothing outstanding (e.g. stale traffic from before reset) are dropped.
  // With pending > 0 the selected master is the owner; otherwise it is the one issuing now.
  assign ack_vld = rst_ni && mem_ack_i && ((pending != '0) || issue);
  assign err     = mem_misaligned_i | mem_page_fault_i;

  riscv_dmem_arb_pending #(
    .MAX_PENDING (MAX_PENDING)
  ) u_pending (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .inc       (issue),
    .dec       (mem_ack_i),
    .pending   (pending),
    .full      (full),
    .next_zero (next_zero)
  );

  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    case (owner_q)
      NONE: begin
        if (issue) begin
          owner_d = (sel == M1) ? OWN1 : OWN0;
        end
      end
      default: begin
        if (next_zero && !sel_lock && !issue) begin
          owner_d = NONE;
          last_d  = sel;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q <= NONE;
      last_q  <= M1;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign mem_req_o  = issue;
  assign mem_lock_o = rst_ni && sel_lock;
  assign mem_we_o   = (sel == M1) ? m1_we_i   : m0_we_i;
  assign mem_size_o = (sel == M1) ? m1_size_i : m0_size_i;
  assign mem_adr_o  = (sel == M1) ? m1_adr_i  : m0_adr_i;
  assign mem_d_o    = (sel == M1) ? m1_d_i    : m0_d_i;

  assign m0_gnt_o = issue && (sel == M0);
  assign m1_gnt_o = issue && (sel == M1);
  assign m0_ack_o = ack_vld && (sel == M0);
  assign m1_ack_o = ack_vld && (sel == M1);
  assign m0_err_o = m0_ack_o && err;
  assign m1_err_o = m1_ack_o && err;
  assign m0_q_o   = m0_ack_o ? mem_q_i : '0;
  assign m1_q_o   = m1_ack_o ? mem_q_i : '0;

  // An owned bus must never see an ack with nothing outstanding.
  ack_without_txn: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mem_ack_i && (owner_q != NONE)) |-> ((pending != '0) || issue));

endmodule
